// File: rtl/pattern_pwm_rx_pkg.sv
// Shared types for the pattern PWM receiver: counter width and FSM encoding.
package pattern_pwm_rx_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/pattern_rx_bit_timer.sv
// Bit timer for the pattern receiver: tracks position inside the current bit
// (duty_cnt) and the bit index (bit_cnt), and decodes per-cycle strobes.
// The counters hold the position of the *current* cycle; on the start cycle
// the position is forced to bit 0 / offset 0 so the frame begins immediately.
module pattern_rx_bit_timer
  import pattern_pwm_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             adv,
  input  logic [CNT_W-1:0] dlat,
  input  logic [CNT_W-1:0] nlat,
  output logic             bit_first,
  output logic             bit_mid,
  output logic             bit_last,
  output logic             frame_last,
  output logic [CNT_W-1:0] bit_idx
);

  logic [CNT_W-1:0] duty_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cur_duty;

  assign cur_duty   = start ? '0 : duty_cnt;
  assign bit_idx    = start ? '0 : bit_cnt;
  assign bit_first  = (cur_duty == '0);
  assign bit_mid    = (cur_duty == (dlat >> 1));
  assign bit_last   = (cur_duty == dlat);
  assign frame_last = bit_last && (bit_idx == (nlat - CNT_W'(1)));

  // Advance the bit position while a frame is being captured; park at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cnt <= '0;
      bit_cnt  <= '0;
    end else if (adv) begin
      if (bit_last) begin
        duty_cnt <= '0;
        bit_cnt  <= bit_idx + CNT_W'(1);
      end else begin
        duty_cnt <= cur_duty + CNT_W'(1);
        bit_cnt  <= bit_idx;
      end
    end else begin
      duty_cnt <= '0;
      bit_cnt  <= '0;
    end
  end

endmodule

// File: rtl/pattern_pwm_rx.sv
// Pattern PWM receiver: recovers an LSB-first serial pattern where each bit is
// held for duty_num+1 clocks, samples each bit at mid-period, flags any level
// change within a bit period, and pulses valid for one cycle at frame end.
// Handshake: rx_start is a single-cycle strobe, accepted only while busy=0,
// rx_en=1 and 1<=bit_num<=_PAT_WIDTH; valid is a one-cycle pulse with no
// back-pressure, and pat_out/bit_err hold their value until the next valid.
module pattern_pwm_rx
  import pattern_pwm_rx_pkg::*;
#(
  parameter int _PAT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_en,
  input  logic                  rx_start,
  input  logic                  pwm_in,
  input  logic [7:0]            duty_num,
  input  logic [7:0]            bit_num,
  output logic [_PAT_WIDTH-1:0] pat_out,
  output logic                  busy,
  output logic                  valid,
  output logic                  bit_err,
  output logic [1:0]            state_dbg
);

  rx_state_e state, state_nxt;

  logic                  accept;
  logic                  adv;
  logic                  bit_num_ok;
  logic [CNT_W-1:0]      dlat, nlat;
  logic [CNT_W-1:0]      dlat_eff, nlat_eff;
  logic                  bit_first, bit_mid, bit_last, frame_last;
  logic [CNT_W-1:0]      bit_idx;
  logic                  ref_lvl;
  logic                  err_acc, err_nxt;
  logic [_PAT_WIDTH-1:0] shadow, shadow_nxt;

  assign bit_num_ok = (bit_num != 8'd0) && (int'(bit_num) <= _PAT_WIDTH);
  assign accept     = rx_start && rx_en && (state != ST_RUN) && bit_num_ok;
  assign adv        = accept || ((state == ST_RUN) && rx_en);
  // On the start cycle the latches are not loaded yet, so use the live inputs.
  assign dlat_eff   = accept ? duty_num : dlat;
  assign nlat_eff   = accept ? bit_num  : nlat;

  assign busy      = (state == ST_RUN);
  assign valid     = (state == ST_DONE);
  assign state_dbg = state;

  pattern_rx_bit_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept),
    .adv        (adv),
    .dlat       (dlat_eff),
    .nlat       (nlat_eff),
    .bit_first  (bit_first),
    .bit_mid    (bit_mid),
    .bit_last   (bit_last),
    .frame_last (frame_last),
    .bit_idx    (bit_idx)
  );

  // Next shadow word and error flag including the current cycle's contribution.
  always_comb begin
    shadow_nxt = accept ? '0 : shadow;
    for (int i = 0; i < _PAT_WIDTH; i++) begin
      if (bit_mid && (bit_idx == CNT_W'(i))) shadow_nxt[i] = pwm_in;
    end
    err_nxt = (accept ? 1'b0 : err_acc) | (!bit_first && (pwm_in != ref_lvl));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: abort wins over frame end; DONE may chain straight into RUN.
  always_comb begin
    state_nxt = state;
    if ((state == ST_RUN) && !rx_en)     state_nxt = ST_IDLE;
    else if (adv && frame_last)          state_nxt = ST_DONE;
    else if (accept)                     state_nxt = ST_RUN;
    else if (state == ST_DONE)           state_nxt = ST_IDLE;
  end

  // Capture datapath: latches, reference level, shadow word, error and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dlat    <= '0;
      nlat    <= '0;
      ref_lvl <= 1'b0;
      err_acc <= 1'b0;
      shadow  <= '0;
      pat_out <= '0;
      bit_err <= 1'b0;
    end else begin
      if (accept) begin
        dlat <= duty_num;
        nlat <= bit_num;
      end
      if (adv) begin
        if (bit_first) ref_lvl <= pwm_in;
        shadow  <= shadow_nxt;
        err_acc <= err_nxt;
        if (frame_last) begin
          pat_out <= shadow_nxt;
          bit_err <= err_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_pwm_rx.sv
// Directed bench for pattern_pwm_rx: table of frames with hand-computed words,
// plus sequences for illegal length, abort, back-to-back and mid-frame reset.
module tb_pattern_pwm_rx;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx_en, rx_start, pwm_in;
  logic [7:0] duty_num, bit_num;
  logic [7:0] pat_out;
  logic       busy, valid, bit_err;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  pattern_pwm_rx #(._PAT_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_en     (rx_en),
    .rx_start  (rx_start),
    .pwm_in    (pwm_in),
    .duty_num  (duty_num),
    .bit_num   (bit_num),
    .pat_out   (pat_out),
    .busy      (busy),
    .valid     (valid),
    .bit_err   (bit_err),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic [7:0] pat;
    logic [7:0] duty;
    logic [7:0] nbits;
    bit         gl;
    int         gb;
    int         go;
    logic [7:0] e_pat;
    logic       e_err;
    string      name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // driver: transmits one frame, rx_start on cycle 0, optional 1-cycle glitch
  task automatic run_frame(input vec_t v);
    int p, len, early, notbusy;
    logic [7:0] pt;
    p = int'(v.duty) + 1;
    len = int'(v.nbits) * p;
    early = 0;
    notbusy = 0;
    pt = v.pat;
    for (int c = 0; c < len; c++) begin
      pwm_in   = pt[c / p] ^ (v.gl && (c / p == v.gb) && (c % p == v.go));
      rx_start = (c == 0);
      if (c == 0) begin
        duty_num = v.duty;
        bit_num  = v.nbits;
      end else begin
        duty_num = 8'($urandom_range(0, 255));
        bit_num  = 8'($urandom_range(0, 255));
      end
      cyc();
      if (c + 1 < len) begin
        if (valid) early++;
        if (!busy) notbusy++;
      end
    end
    rx_start = 1'b0;
    pwm_in   = 1'b0;
    check({v.name, ".early_valid"}, early, 0);
    check({v.name, ".busy_in_frame"}, notbusy, 0);
    check({v.name, ".valid"}, valid, 1);
    check({v.name, ".busy_end"}, busy, 0);
    check({v.name, ".pat"}, pat_out, v.e_pat);
    check({v.name, ".err"}, bit_err, v.e_err);
    cyc();
    check({v.name, ".valid_one_cycle"}, valid, 0);
  endtask

  initial begin
    int seen;
    int vcyc[2];
    logic [7:0] pt;

    vecs[0] = '{8'hB5, 8'd3, 8'd8, 1'b0, 0, 0, 8'hB5, 1'b0, "loopback_b5"};
    vecs[1] = '{8'h05, 8'd0, 8'd3, 1'b0, 0, 0, 8'h05, 1'b0, "short_p1"};
    vecs[2] = '{8'h00, 8'd3, 8'd8, 1'b1, 2, 1, 8'h04, 1'b1, "glitch_mid"};
    vecs[3] = '{8'h00, 8'd3, 8'd8, 1'b1, 5, 3, 8'h00, 1'b1, "glitch_last"};
    vecs[4] = '{8'hFF, 8'd0, 8'd8, 1'b1, 3, 0, 8'hF7, 1'b0, "p1_no_flag"};
    vecs[5] = '{8'hA5, 8'd2, 8'd4, 1'b0, 0, 0, 8'h05, 1'b0, "n4_upper_zero"};
    vecs[6] = '{8'h00, 8'd2, 8'd8, 1'b1, 1, 0, 8'h00, 1'b1, "glitch_first"};
    vecs[7] = '{8'h00, 8'd1, 8'd8, 1'b1, 0, 1, 8'h00, 1'b1, "glitch_p2"};
    vecs[8] = '{8'h3C, 8'd1, 8'd8, 1'b0, 0, 0, 8'h3C, 1'b0, "p2_3c"};

    rst_n = 1'b0; rx_en = 1'b0; rx_start = 1'b0; pwm_in = 1'b0;
    duty_num = 8'd0; bit_num = 8'd0;
    #23;
    check("rst.pat", pat_out, 0);
    check("rst.busy", busy, 0);
    check("rst.valid", valid, 0);
    check("rst.err", bit_err, 0);
    check("rst.state", state_dbg, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_en = 1'b1;
    cyc();

    for (int i = 0; i < 9; i++) run_frame(vecs[i]);

    // illegal frame lengths are ignored
    for (int k = 0; k < 2; k++) begin
      seen = 0;
      duty_num = 8'd1;
      bit_num  = (k == 0) ? 8'd0 : 8'd9;
      rx_start = 1'b1;
      cyc();
      rx_start = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (busy || valid) seen++;
        cyc();
      end
      check(k == 0 ? "illegal_n0" : "illegal_n9", seen, 0);
    end
    check("illegal.pat_kept", pat_out, 8'h3C);

    // abort: rx_en low in cycle 10 -> busy low in cycle 11, no valid
    for (int c = 0; c <= 10; c++) begin
      pwm_in   = 1'b1;
      rx_start = (c == 0);
      duty_num = 8'd3;
      bit_num  = 8'd8;
      if (c == 10) rx_en = 1'b0;
      cyc();
      if (c == 9) check("abort.busy_before", busy, 1);
    end
    rx_start = 1'b0;
    check("abort.busy_c11", busy, 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid || busy) seen++;
      cyc();
    end
    check("abort.no_valid", seen, 0);
    check("abort.pat_kept", pat_out, 8'h3C);
    check("abort.err_kept", bit_err, 0);
    rx_en = 1'b1;
    cyc();

    // back-to-back: B5 then 3C, second start in the valid cycle; stray start at cycle 5
    exp_q.push_back(8'hB5);
    exp_q.push_back(8'h3C);
    seen = 0;
    duty_num = 8'd3;
    bit_num  = 8'd8;
    for (int c = 0; c < 64; c++) begin
      pt       = (c < 32) ? 8'hB5 : 8'h3C;
      pwm_in   = pt[(c % 32) / 4];
      rx_start = (c == 0) || (c == 5) || (c == 32);
      cyc();
      if (valid) begin
        if (seen < 2) vcyc[seen] = c + 1;
        seen++;
        if (exp_q.size() > 0) check("b2b.pat", pat_out, exp_q.pop_front());
        else check("b2b.extra_valid", 1, 0);
      end
    end
    rx_start = 1'b0;
    check("b2b.count", seen, 2);
    if (seen >= 2) begin
      check("b2b.first_at_32", vcyc[0], 32);
      check("b2b.spacing", vcyc[1] - vcyc[0], 32);
    end
    check("b2b.queue_empty", exp_q.size(), 0);
    cyc();

    // reset mid-frame returns outputs to reset values at once
    for (int c = 0; c < 10; c++) begin
      pwm_in   = 1'b1;
      rx_start = (c == 0);
      cyc();
    end
    rx_start = 1'b0;
    check("mrst.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst.pat", pat_out, 0);
    check("mrst.busy", busy, 0);
    check("mrst.valid", valid, 0);
    check("mrst.err", bit_err, 0);
    check("mrst.state", state_dbg, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
